// File: rtl/period_sequencer_pkg.sv
// Shared types and constants for the period sequencer.
//   state_t    : sequencer state (IDLE = no active period, RUN = period loaded)
//   MIN_PERIOD : smallest period value the downstream counter can run with,
//                and the value reset_value holds out of reset
package period_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/period_sequencer_fifo.sv
// period_fifo: small synchronous FIFO holding queued period values.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full)
//   push_data  : value to write
//   pop        : advance the read pointer (ignored when empty)
//   head_c     : entry at the read pointer (combinational read)
//   full/empty : registered status flags
//   level      : registered number of stored entries
// When LOOP is set a pop does not consume: the read pointer walks
// circularly over the entries written so far and level never drops.
module period_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter bit          LOOP  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  // Next occupancy and read pointer; loop mode keeps entries and wraps
  // the read pointer at the (post-push) number of written entries.
  always_comb begin
    level_next  = level;
    rd_ptr_next = rd_ptr;
    if (do_push) begin
      level_next = level_next + LVL_W'(1);
    end
    if (do_pop) begin
      if (LOOP) begin
        if ((LVL_W'(rd_ptr) + LVL_W'(1)) >= level_next) begin
          rd_ptr_next = '0;
        end else begin
          rd_ptr_next = PTR_W'(rd_ptr + PTR_W'(1));
        end
      end else begin
        level_next  = level_next - LVL_W'(1);
        rd_ptr_next = PTR_W'(rd_ptr + PTR_W'(1));
      end
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, level and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      end
      rd_ptr <= rd_ptr_next;
      level  <= level_next;
      full   <= (level_next == LVL_W'(DEPTH));
      empty  <= (level_next == '0);
    end
  end

endmodule

// File: rtl/period_sequencer.sv
// period_sequencer: feeds a downstream counter with period values taken
// from a small FIFO and paces increment pulses from a pending-tick count.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   tick_in       : request for one downstream increment
//   period_in     : period value to enqueue (values below 2 are rejected)
//   period_valid  : write request; accepted when period_ready is high
//   period_ready  : FIFO can accept a write
//   cnt_ready     : downstream counter can take an enable
//   cnt_strobe    : downstream terminal-count strobe (period finished)
//   enable        : increment pulse, never on two consecutive cycles
//   reset_value   : active period presented to the downstream counter
//   busy          : a period is active (state RUN)
//   err_overflow  : sticky, a tick was dropped at pending saturation
//   err_period    : sticky, a write with period_in < 2 was rejected
// Build option: define PERIOD_SEQ_LOOP_EN to replay the queued periods
// circularly; writes are then only accepted while IDLE.
module period_sequencer
  import period_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PEND_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] period_in,
  input  logic             period_valid,
  output logic             period_ready,
  input  logic             cnt_ready,
  input  logic             cnt_strobe,
  output logic             enable,
  output logic [WIDTH-1:0] reset_value,
  output logic             busy,
  output logic             err_overflow,
  output logic             err_period
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

`ifdef PERIOD_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t            state;
  logic [PEND_W-1:0] pending;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [WIDTH-1:0]  head;
  logic              period_ok;
  logic              push;
  logic              pop;
  logic              strobe_take;
  logic              issue;

`ifdef PERIOD_SEQ_LOOP_EN
  assign period_ready = !fifo_full && (state == IDLE);
`else
  assign period_ready = !fifo_full;
`endif

  assign period_ok = (period_in >= WIDTH'(MIN_PERIOD));
  assign push      = period_valid && period_ready && period_ok;

  // A strobe is acted on only while enable is low, so reset_value never
  // changes under an increment that is in flight.
  assign strobe_take = (state == RUN) && cnt_strobe && !enable;

  // Load on IDLE->RUN, or reload on a strobe when another period is queued.
  assign pop = !fifo_empty && ((state == IDLE) || strobe_take);

  // Issue an increment; the strobe/reload edge is kept free of enables.
  assign issue = (state == RUN) && (pending != '0) && cnt_ready &&
                 !enable && !strobe_take;

  period_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LOOP  (LOOP_EN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (period_in),
    .pop       (pop),
    .head_c    (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Sequencer FSM, pending counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      pending      <= '0;
      enable       <= 1'b0;
      reset_value  <= WIDTH'(MIN_PERIOD);
      err_overflow <= 1'b0;
      err_period   <= 1'b0;
    end else begin
      enable <= issue;

      // Tick and issue in the same cycle cancel out.
      if (tick_in && !issue) begin
        if (pending == PEND_MAX) begin
          err_overflow <= 1'b1;
        end else begin
          pending <= pending + PEND_W'(1);
        end
      end else if (!tick_in && issue) begin
        pending <= pending - PEND_W'(1);
      end

      if (period_valid && !period_ok) begin
        err_period <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state       <= RUN;
            busy        <= 1'b1;
            reset_value <= head;
          end
        end
        RUN: begin
          if (strobe_take) begin
            if (!fifo_empty) begin
              reset_value <= head;
            end else if (!LOOP_EN) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping sanity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (fifo_level <= LVL_W'(DEPTH));
      assert (fifo_empty == (fifo_level == '0));
    end
  end

endmodule

// File: tb/tb_period_sequencer.sv
// Self-checking bench for period_sequencer (WIDTH=4, DEPTH=4, PEND_W=2).
// Expected reset_value per increment is queued when a tick is driven and
// compared when the DUT raises enable.
module tb_period_sequencer;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PEND_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick_in = 1'b0;
  logic [WIDTH-1:0] period_in = '0;
  logic             period_valid = 1'b0;
  logic             period_ready;
  logic             cnt_ready = 1'b1;
  logic             cnt_strobe = 1'b0;
  logic             enable;
  logic [WIDTH-1:0] reset_value;
  logic             busy;
  logic             err_overflow;
  logic             err_period;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  period_sequencer #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .PEND_W (PEND_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_in      (tick_in),
    .period_in    (period_in),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .cnt_ready    (cnt_ready),
    .cnt_strobe   (cnt_strobe),
    .enable       (enable),
    .reset_value  (reset_value),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_period   (err_period)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every enable pops one expected period.
  always @(negedge clk) begin
    if (!rst && enable) begin
      check("no_back_to_back", int'(prev_en), 0);
      if (exp_q.size() == 0) check("unexpected_enable", 1, 0);
      else check("enable_period", int'(reset_value), int'(exp_q.pop_front()));
    end
    prev_en = enable;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick_in = 1'b0; period_valid = 1'b0; cnt_strobe = 1'b0; cnt_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_q_empty", exp_q.size(), 0);
    exp_q.delete();
    step();
    check("rst_reset_value", int'(reset_value), 2);
    check("rst_enable", int'(enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err_overflow", int'(err_overflow), 0);
    check("rst_err_period", int'(err_period), 0);
    check("rst_period_ready", int'(period_ready), 1);
  endtask

  task automatic write(input int v);
    period_valid = 1'b1;
    period_in = WIDTH'(v);
    step();
    period_valid = 1'b0;
  endtask

  task automatic tick(input int expv, input int gap);
    tick_in = 1'b1;
    exp_q.push_back(WIDTH'(expv));
    step();
    tick_in = 1'b0;
    repeat (gap) step();
  endtask

  task automatic strobe();
    cnt_strobe = 1'b1;
    step();
    cnt_strobe = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Single period, six spaced ticks.
    do_reset();
    write(3);
    step();
    check("t1_busy", int'(busy), 1);
    check("t1_reset_value", int'(reset_value), 3);
    for (int i = 0; i < 6; i++) tick(3, 3);
    drain("t1_drain");

`ifndef PERIOD_SEQ_LOOP_EN
    // Two queued periods; reload on strobe with enable held low.
    do_reset();
    period_valid = 1'b1; period_in = WIDTH'(3); step();
    period_in = WIDTH'(5); step();
    period_valid = 1'b0;
    check("t2_load", int'(reset_value), 3);
    for (int i = 0; i < 3; i++) tick(3, 2);
    drain("t2_drain_a");
    tick(5, 0);
    strobe();
    check("t2_reload", int'(reset_value), 5);
    check("t2_strobe_enable", int'(enable), 0);
    check("t2_busy", int'(busy), 1);
    drain("t2_drain_b");
    strobe();
    check("t2_idle_busy", int'(busy), 0);
    check("t2_idle_hold", int'(reset_value), 5);
`endif

    // Pending saturation with ticks arriving in IDLE.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick_in = 1'b1;
      step();
      if (i == 3) check("t3_ovf_before", int'(err_overflow), 0);
      if (i == 4) check("t3_ovf_after", int'(err_overflow), 1);
    end
    tick_in = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(WIDTH'(7));
    write(7);
    drain("t3_drain");
    check("t3_ovf_sticky", int'(err_overflow), 1);

    // Rejected short period.
    do_reset();
    write(1);
    check("t4_err_period", int'(err_period), 1);
    check("t4_ready", int'(period_ready), 1);
    step(); step();
    check("t4_idle", int'(busy), 0);

`ifndef PERIOD_SEQ_LOOP_EN
    // Fill to full, refused write, then mid-RUN reset.
    do_reset();
    period_valid = 1'b1;
    for (int v = 4; v <= 8; v++) begin
      period_in = WIDTH'(v);
      step();
    end
    period_valid = 1'b0;
    check("t5_full_ready", int'(period_ready), 0);
    write(9);
    check("t5_still_full", int'(period_ready), 0);
    check("t5_head", int'(reset_value), 4);
    for (int v = 5; v <= 8; v++) begin
      strobe();
      check("t5_seq", int'(reset_value), v);
    end
    strobe();
    check("t5_empty_idle", int'(busy), 0);
    step();
    check("t5_nine_lost", int'(busy), 0);
    check("t5_hold", int'(reset_value), 8);

    write(3);
    step();
    cnt_ready = 1'b0;
    tick_in = 1'b1; step(); tick_in = 1'b0;
    write(4);
    rst = 1'b1;
    step();
    check("t5_rst_rv", int'(reset_value), 2);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_enable", int'(enable), 0);
    check("t5_rst_ready", int'(period_ready), 1);
    rst = 1'b0;
    cnt_ready = 1'b1;
    step();
    write(6);
    step();
    check("t5_fresh_load", int'(reset_value), 6);
    repeat (10) step();
    check("t5_no_stray", int'(enable), 0);
`else
    // Loop mode: queued periods replay circularly.
    do_reset();
    period_valid = 1'b1; period_in = WIDTH'(2); step();
    period_in = WIDTH'(4); step();
    period_valid = 1'b0;
    check("loop_load", int'(reset_value), 2);
    for (int i = 0; i < 4; i++) begin
      strobe();
      check("loop_seq", int'(reset_value), (i % 2 == 0) ? 4 : 2);
    end
    check("loop_busy", int'(busy), 1);
    check("loop_ready", int'(period_ready), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
